// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial data, config and result signals of the pattern detector.
interface seq_detector_param_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    parameter int LEN_W = $clog2(PAT_W) + 1
);
    logic             en;
    logic             din;
    logic             cfg_wr;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap;
    logic             cnt_clr;
    logic             dout;
    logic [CNT_W-1:0] hit_cnt;
    modport master (output en, din, cfg_wr, pattern, pat_len, overlap, cnt_clr, input dout, hit_cnt);
    modport slave  (input en, din, cfg_wr, pattern, pat_len, overlap, cnt_clr, output dout, hit_cnt);
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector with overlap mode.
// Optional saturating hit counter enabled by defining SEQ_HITCNT_EN.
module seq_detector_param #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    seq_detector_param_if.slave bus
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    typedef enum logic [1:0] {DISABLED, FILLING, ARMED} state_t;

    logic [PAT_W-1:0] hist, hist_n, cfg_pat, cfg_pat_n, mask;
    logic [LEN_W-1:0] fill, fill_n, cfg_len, cfg_len_n;
    logic             cfg_ovl, cfg_ovl_n, hit, dout_q;
    state_t           state_n;

    always_comb begin
        hist_n    = hist;
        fill_n    = fill;
        cfg_pat_n = cfg_pat;
        cfg_len_n = cfg_len;
        cfg_ovl_n = cfg_ovl;
        mask      = ~({PAT_W{1'b1}} << cfg_len);
        if (bus.cfg_wr) begin
            cfg_pat_n = bus.pattern;
            cfg_len_n = (bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
            cfg_ovl_n = bus.overlap;
            fill_n    = '0;
        end else if (bus.en) begin
            hist_n = {hist[PAT_W-2:0], bus.din};
            fill_n = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        end
        state_n = (cfg_len_n == '0) ? DISABLED : (fill_n < cfg_len_n) ? FILLING : ARMED;
        // a config write in the same cycle suppresses any match
        hit = bus.en && !bus.cfg_wr && (state_n == ARMED) && (((hist_n ^ cfg_pat) & mask) == '0);
        if (hit && !cfg_ovl) fill_n = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist    <= '0;
            fill    <= '0;
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b1;
            dout_q  <= 1'b0;
        end else begin
            hist    <= hist_n;
            fill    <= fill_n;
            cfg_pat <= cfg_pat_n;
            cfg_len <= cfg_len_n;
            cfg_ovl <= cfg_ovl_n;
            dout_q  <= hit;
        end
    end

    assign bus.dout = dout_q;

`ifdef SEQ_HITCNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (bus.cnt_clr) cnt <= '0;
        else if (hit && cnt != '1) cnt <= cnt + 1'b1;
    end

    assign bus.hit_cnt = cnt;
`else
    assign bus.hit_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench comparing dout/hit_cnt against a bit-window model.
module tb_seq_detector_param;
    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {bit d; int c;} exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0, n_bad = 0, hits = 0;
    int   mlen, mcnt;
    logic [PAT_W-1:0] mpat;
    bit   movl;
    bit   win[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();
    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // last received bit corresponds to mpat[0], earliest to mpat[mlen-1]
    task automatic model_bit(input bit b, output bit h);
        win.push_back(b);
        if (win.size() > PAT_W) void'(win.pop_front());
        h = 1'b0;
        if (mlen != 0 && win.size() >= mlen) begin
            h = 1'b1;
            for (int k = 0; k < mlen; k++)
                if (win[win.size()-1-k] != mpat[k]) h = 1'b0;
        end
        if (h && !movl) win.delete();
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_dout"}, bus.dout, e.d);
            chk({tag, "_cnt"}, bus.hit_cnt, e.c);
            hits += int'(bus.dout);
        end
    endtask

    task automatic step(input string tag, input bit e, input bit b, input bit clr = 1'b0);
        exp_t x;
        bit h;
        @(negedge clk);
        bus.cfg_wr = 1'b0;
        bus.en = e;
        bus.din = b;
        bus.cnt_clr = clr;
        h = 1'b0;
        if (e) model_bit(b, h);
`ifdef SEQ_HITCNT_EN
        if (clr) mcnt = 0;
        else if (h && mcnt < CMAX) mcnt++;
`endif
        x.d = h;
        x.c = mcnt;
        sb.push_back(x);
        @(posedge clk);
        #1 pop_check(tag);
    endtask

    task automatic cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len, input bit ovl);
        exp_t x;
        @(negedge clk);
        bus.cfg_wr = 1'b1;
        bus.pattern = pat;
        bus.pat_len = len;
        bus.overlap = ovl;
        bus.en = 1'b1;
        bus.din = 1'b1;
        bus.cnt_clr = 1'b0;
        mlen = (int'(len) > PAT_W) ? PAT_W : int'(len);
        mpat = pat;
        movl = ovl;
        win.delete();
        x.d = 1'b0;
        x.c = mcnt;
        sb.push_back(x);
        @(posedge clk);
        #1 pop_check("cfg");
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.en = 1'b0;
        bus.cfg_wr = 1'b0;
        bus.cnt_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_cnt", bus.hit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mlen = 0;
        mpat = '0;
        movl = 1'b1;
        mcnt = 0;
        win.delete();
        sb.delete();
    endtask

    task automatic stream(input string tag, input logic [31:0] bits, input int n, input int exp_hits);
        hits = 0;
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i]);
        chk({tag, "_hits"}, hits, exp_hits);
    endtask

    initial begin
        bus.en = 1'b0;
        bus.din = 1'b0;
        bus.cfg_wr = 1'b0;
        bus.pattern = '0;
        bus.pat_len = '0;
        bus.overlap = 1'b1;
        bus.cnt_clr = 1'b0;
        do_reset();
        step("idle", 1'b1, 1'b1);
        cfg(8'b111, 4'd3, 1'b1);
        stream("t1", 32'b11111, 5, 3);
        cfg(8'b1011, 4'd4, 1'b1);
        stream("t2", 32'b1011011, 7, 2);
        cfg(8'b1011, 4'd4, 1'b0);
        stream("t3", 32'b1011011, 7, 1);
        cfg(8'b1011, 4'd4, 1'b1);
        stream("t4a", 32'b101, 3, 0);
        do_reset();
        cfg(8'b1011, 4'd4, 1'b1);
        stream("t4b", 32'b1, 1, 0);
        stream("t4c", 32'b1011, 4, 1);
        cfg(8'hA5, 4'd0, 1'b1);
        hits = 0;
        for (int i = 0; i < 100; i++) step("t5a", 1'b1, 1'($urandom_range(1)));
        chk("t5a_hits", hits, 0);
        cfg(8'hFF, 4'(PAT_W + 3), 1'b1);
        stream("t5b", 32'h3FF, PAT_W + 2, 3);
        cfg(8'b111, 4'd3, 1'b1);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            step("t6a", 1'b1, 1'b1);
            step("t6a_gap", 1'b0, 1'b0);
        end
        chk("t6a_hits", hits, 3);
        step("t6_clr", 1'b0, 1'b0, 1'b1);
        stream("t6b", 32'b11111, 5, 5);
        step("t6_clr_hit", 1'b1, 1'b1, 1'b1);
        step("t6_after", 1'b1, 1'b0);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
